// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide engine for the integer pipeline.
// Shift-add multiply and restoring divide, one bit per clock.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] lo_nx;
  logic [WIDTH-1:0] res_nx;

  // acc holds the product high half or the partial remainder;
  // lo holds the product low half or the shifting quotient.
  always_comb begin
    sum    = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    shl    = {acc, lo[WIDTH-1]};
    diff   = shl[WIDTH-1:0] - opnd;
    acc_nx = acc;
    lo_nx  = lo;
    if (op_q[1]) begin
      if (shl >= {1'b0, opnd}) begin
        acc_nx = diff;
        lo_nx  = {lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = shl[WIDTH-1:0];
        lo_nx  = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nx = sum[WIDTH:1];
      lo_nx  = {sum[0], lo[WIDTH-1:1]};
    end
    res_nx = op_q[0] ? acc_nx : lo_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      opnd   <= '0;
      acc    <= '0;
      lo     <= '0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            cnt  <= CW'(WIDTH - 1);
            opnd <= op[1] ? b : a;
            acc  <= '0;
            lo   <= op[1] ? a : b;
            if (op[1] && (b == '0)) begin
              result <= op[0] ? a : '1;
              state  <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= acc_nx;
          lo  <= lo_nx;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            result <= res_nx;
            state  <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign stall = reset &
                 (((state == IDLE) & start & ~flush) |
                  (state == RUN));

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multi-cycle multiply/divide engine with its own sequencing FSM.
- Sits beside the single-cycle ALU and offloads the combinational multiply and divide paths.
- The core's decoder raises start with operands. The block drives stall to hold the PC register until the result is ready.
- Unsigned operations only: MUL, MULHU, DIVU, REMU.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count of one operation

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset (0 = reset asserted)
start  in  1  request; sampled only in IDLE
op  in  2  00 MUL (low half), 01 MULHU (high half), 10 DIVU (quotient), 11 REMU (remainder)
a  in  WIDTH  multiplicand / dividend
b  in  WIDTH  multiplier / divisor
flush  in  1  synchronous abort
busy  out  1  1 in RUN
stall  out  1  hold core PC/regfile write
done  out  1  one-cycle pulse; result valid
result  out  WIDTH  last completed result; holds until next done

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (reset=0, async): state IDLE, counter 0, internal product/quotient/remainder registers 0; result=0, busy=0, done=0, stall=0. Reset mid-RUN discards the operation.
- Outputs:
  - busy = (state==RUN).
  - done = (state==DONE).
  - stall = (state==IDLE & start & ~flush) | (state==RUN). Stall is combinational and asserts in the request cycle itself.
  - stall=0 in DONE, so the core advances and writes result that cycle.
- IDLE, start=1 and flush=0 at edge N:
  - Latch a, b and op. Load counter WIDTH-1.
  - If op[1]=1 and b==0: go to DONE directly (done after edge N+1 is not used; done=1 in cycle after edge N). Result is loaded at that edge: DIVU gives all ones; REMU gives a.
  - Otherwise go to RUN.
- RUN: one iteration per edge, edges N+1 through N+WIDTH.
  - Counter decrements each edge. At the edge where counter==0, load result and go to DONE.
  - done=1 in the cycle after edge N+WIDTH, so latency is WIDTH+1 cycles from the accept edge.
- MUL/MULHU, shift-add on a 2*WIDTH product register {hi, lo}:
  - lo initialised to b, hi to 0.
  - Each step: if lo[0], hi = hi + a with a WIDTH+1-bit carry kept.
  - Then shift the {carry, hi, lo} concatenation right by 1.
  - Final: MUL gives lo; MULHU gives hi.
- DIVU/REMU, restoring division:
  - rem (WIDTH+1 bits) initialised to 0; quotient register initialised to a.
  - Each step: rem = {rem[WIDTH-1:0], q[MSB]}; q <<= 1.
  - If rem >= b: rem -= b and q[0] = 1.
  - Final: DIVU gives q; REMU gives rem[WIDTH-1:0].
- DONE: unconditional return to IDLE at the next edge. start is ignored in DONE; back-to-back ops therefore cost one IDLE cycle.
- flush=1, synchronous, highest priority after reset:
  - Any state goes to IDLE at the next edge.
  - A RUN in progress is dropped: no done, result unchanged.
  - flush in IDLE suppresses acceptance of a simultaneous start.
  - flush in DONE: done still pulses that cycle; result is already updated.
- Operand changes on a/b/op after acceptance have no effect.
- All arithmetic is unsigned. There is no overflow case: the product is exact in 2*WIDTH bits.

Test Plan:
- MUL 7×6: start at edge N → stall=1 edges N..N+WIDTH; done=1 only in cycle after edge N+32; result=0x0000002A; busy=1 for exactly 32 cycles.
- a=b=0xFFFFFFFF: MUL → 0x00000001; MULHU → 0xFFFFFFFE. Back-to-back: second start held across DONE and accepted only in IDLE.
- DIVU 100/7 → 0x0000000E; REMU 100/7 → 0x00000002. Also DIVU 5/9 → 0 and REMU 5/9 → 5.
- Divide by zero: DIVU 123/0 → done in cycle after accept edge, result=0xFFFFFFFF. REMU 5/0 → 0x00000005. busy never asserts.
- flush at RUN iteration 10 after a prior result 0x2A: IDLE next edge, done never pulses, result stays 0x0000002A, stall=0. start+flush together in IDLE → not accepted.
- reset=0 asynchronously mid-RUN (between edges) → busy, stall, done and result go to 0 immediately. After release, a fresh MUL 3×3 → 0x00000009 with full WIDTH+1 latency.
